// File: rtl/byteswap_stream_source.sv
// AXI4-Stream test-pattern source: emits a counted burst of incrementing words,
// optionally byte-reversed so a downstream byte-swapper yields a natural count.
module byteswap_stream_source #(
   parameter int C_AXIS_TDATA_WIDTH = 512,
   parameter int C_WORD_BIT_WIDTH   = 32,
   parameter int C_LENGTH_WIDTH     = 32,
   parameter int C_PRESWAP          = 0
) (
   input  logic                            m_axis_aclk,
   input  logic                            m_axis_areset,
   input  logic                            ctrl_start,
   input  logic [C_LENGTH_WIDTH-1:0]       ctrl_length,
   input  logic [C_WORD_BIT_WIDTH-1:0]     ctrl_constant,
   output logic                            ctrl_busy,
   output logic                            ctrl_done,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                            m_axis_tlast
);

   localparam int LP_NUM_WORDS = C_AXIS_TDATA_WIDTH / C_WORD_BIT_WIDTH;
   localparam int LP_NUM_BYTES = C_WORD_BIT_WIDTH / 8;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                          r_state;
   state_t                          w_next;
   logic [C_LENGTH_WIDTH-1:0]       r_remaining;
   logic [C_WORD_BIT_WIDTH-1:0]     r_base;
   logic [C_AXIS_TDATA_WIDTH-1:0]   r_tdata;
   logic                            r_tvalid;
   logic                            r_tlast;
   logic                            r_busy;
   logic                            r_done;

   logic                            w_start;
   logic                            w_handshake;
   logic                            w_lastBeat;
   logic                            w_nextLast;
   logic [C_WORD_BIT_WIDTH-1:0]     w_beatBase;
   logic [C_WORD_BIT_WIDTH-1:0]     w_word;
   logic [C_AXIS_TDATA_WIDTH-1:0]   w_beatData;

   assign w_start     = (r_state == S_IDLE) && ctrl_start;
   assign w_handshake = r_tvalid && m_axis_tready;
   assign w_lastBeat  = w_handshake && r_tlast;

   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (ctrl_start) begin
               w_next = (ctrl_length == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (w_lastBeat) begin
               w_next = S_DONE;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // The register stage always holds the beat on the wire, so the next beat is
   // prepared from the word base that will apply once the current one is taken.
   always_comb begin
      w_beatBase = w_start ? ctrl_constant : r_base;
      w_nextLast = w_start ? (ctrl_length == C_LENGTH_WIDTH'(1))
                           : (r_remaining == C_LENGTH_WIDTH'(2));
      w_word     = '0;
      w_beatData = '0;
      for (int k = 0; k < LP_NUM_WORDS; k++) begin
         w_word = w_beatBase + C_WORD_BIT_WIDTH'(k);
         if (C_PRESWAP != 0) begin
            for (int j = 0; j < LP_NUM_BYTES; j++) begin
               w_beatData[k*C_WORD_BIT_WIDTH + j*8 +: 8] = w_word[(LP_NUM_BYTES-1-j)*8 +: 8];
            end
         end else begin
            w_beatData[k*C_WORD_BIT_WIDTH +: C_WORD_BIT_WIDTH] = w_word;
         end
      end
   end

   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         r_remaining <= '0;
         r_base      <= '0;
         r_tdata     <= '0;
         r_tvalid    <= 1'b0;
         r_tlast     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_tvalid <= (w_next == S_RUN);
         r_busy   <= (w_next != S_IDLE);
         r_done   <= (w_next == S_DONE);
         if (w_start) begin
            r_remaining <= ctrl_length;
            r_base      <= ctrl_constant + C_WORD_BIT_WIDTH'(LP_NUM_WORDS);
            r_tdata     <= w_beatData;
            r_tlast     <= w_nextLast;
         end else if (w_handshake) begin
            r_remaining <= r_remaining - C_LENGTH_WIDTH'(1);
            r_base      <= r_base + C_WORD_BIT_WIDTH'(LP_NUM_WORDS);
            r_tdata     <= w_beatData;
            r_tlast     <= w_nextLast;
         end
      end
   end

   assign ctrl_busy     = r_busy;
   assign ctrl_done     = r_done;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tdata  = r_tdata;
   assign m_axis_tlast  = r_tlast;
   assign m_axis_tkeep  = '1;

endmodule

// File: tb/tb_byteswap_stream_source.sv
// Bench for byteswap_stream_source: directed scenarios plus randomized bursts
// checked against an arithmetic model of the expected counter words.
module tb_byteswap_stream_source;

   localparam int W  = 512;
   localparam int NW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          startA, startB;
   logic [31:0]   len, cst;
   logic          ready;

   logic          busyA, doneA, validA, lastA;
   logic [W-1:0]  dataA;
   logic [63:0]   keepA;
   logic          busyB, doneB, validB, lastB;
   logic [W-1:0]  dataB;
   logic [63:0]   keepB;

   int nChecks = 0;
   int nPass   = 0;

   always #5 clk = ~clk;

   byteswap_stream_source #(.C_PRESWAP(0)) dutA (
      .m_axis_aclk(clk), .m_axis_areset(reset), .ctrl_start(startA),
      .ctrl_length(len), .ctrl_constant(cst), .ctrl_busy(busyA), .ctrl_done(doneA),
      .m_axis_tvalid(validA), .m_axis_tready(ready), .m_axis_tdata(dataA),
      .m_axis_tkeep(keepA), .m_axis_tlast(lastA));

   byteswap_stream_source #(.C_PRESWAP(1)) dutB (
      .m_axis_aclk(clk), .m_axis_areset(reset), .ctrl_start(startB),
      .ctrl_length(len), .ctrl_constant(cst), .ctrl_busy(busyB), .ctrl_done(doneB),
      .m_axis_tvalid(validB), .m_axis_tready(ready), .m_axis_tdata(dataB),
      .m_axis_tkeep(keepB), .m_axis_tlast(lastB));

   // Word k of beat b is simply constant + b*16 + k, optionally byte-reversed.
   function automatic logic [31:0] modelWord(input logic [31:0] c, input int beat, input int k, input bit swap);
      logic [31:0] v;
      v = c + 32'(beat*NW + k);
      if (swap) v = {v[7:0], v[15:8], v[23:16], v[31:24]};
      return v;
   endfunction

   function automatic logic [W-1:0] modelBeat(input logic [31:0] c, input int beat, input bit swap);
      logic [W-1:0] d;
      d = '0;
      for (int k = 0; k < NW; k++) d[k*32 +: 32] = modelWord(c, beat, k, swap);
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else begin
         $display("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
         $error("[TB] %s differs", tag);
      end
   endtask

   // readyMode: 0 = always ready, 1 = random ready, 2 = fixed pattern with a stray start.
   task automatic applyStimulus(input logic [31:0] c, input int L, input int readyMode, input string tag);
      int beat;
      int cyc;
      logic [6:0] pat;
      pat  = 7'b1101001;
      ready = 1'b1;
      cst = c; len = 32'(L); startA = 1'b1;
      tick();
      startA = 1'b0; cst = $urandom; len = $urandom;
      if (L == 0) begin
         checkOutput({tag, ".done"}, doneA, 1);
         checkOutput({tag, ".valid"}, validA, 0);
         checkOutput({tag, ".busy"}, busyA, 1);
         tick();
         checkOutput({tag, ".doneAfter"}, doneA, 0);
         checkOutput({tag, ".busyAfter"}, busyA, 0);
         checkOutput({tag, ".validAfter"}, validA, 0);
         return;
      end
      beat = 0;
      cyc  = 0;
      while (beat < L && cyc < 400) begin
         case (readyMode)
            0:       ready = 1'b1;
            1:       ready = 1'($urandom_range(0, 1));
            default: ready = (cyc < 7) ? pat[cyc] : 1'b1;
         endcase
         startA = (readyMode == 2 && cyc == 2);
         checkOutput($sformatf("%s.valid%0d", tag, cyc), validA, 1);
         checkOutput($sformatf("%s.data%0d", tag, cyc), dataA, modelBeat(c, beat, 1'b0));
         checkOutput($sformatf("%s.last%0d", tag, cyc), lastA, (beat == L-1));
         checkOutput($sformatf("%s.keep%0d", tag, cyc), keepA, 64'hFFFF_FFFF_FFFF_FFFF);
         checkOutput($sformatf("%s.done%0d", tag, cyc), doneA, 0);
         if (ready) beat++;
         tick();
         cyc++;
      end
      startA = 1'b0;
      ready  = 1'b1;
      checkOutput({tag, ".handshakes"}, beat, L);
      checkOutput({tag, ".done"}, doneA, 1);
      checkOutput({tag, ".validEnd"}, validA, 0);
      checkOutput({tag, ".busyEnd"}, busyA, 1);
      tick();
      checkOutput({tag, ".doneAfter"}, doneA, 0);
      checkOutput({tag, ".busyAfter"}, busyA, 0);
   endtask

   initial begin
      logic [31:0] saved;
      reset = 1'b1; startA = 1'b0; startB = 1'b0; len = '0; cst = '0; ready = 1'b1;
      tick();
      tick();
      checkOutput("reset.valid", validA, 0);
      checkOutput("reset.last", lastA, 0);
      checkOutput("reset.data", dataA, 0);
      checkOutput("reset.keep", keepA, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("reset.busy", busyA, 0);
      checkOutput("reset.done", doneA, 0);
      checkOutput("reset.validB", validB, 0);
      reset = 1'b0;
      tick();

      // Basic burst with explicit word values
      cst = 32'h10; len = 3; startA = 1'b1;
      tick();
      startA = 1'b0; cst = '1; len = 0;
      checkOutput("basic.valid0", validA, 1);
      checkOutput("basic.b0w0", dataA[31:0], 32'h10);
      checkOutput("basic.b0w15", dataA[511:480], 32'h1F);
      checkOutput("basic.last0", lastA, 0);
      checkOutput("basic.keep0", keepA, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      checkOutput("basic.b1w0", dataA[31:0], 32'h20);
      checkOutput("basic.last1", lastA, 0);
      tick();
      checkOutput("basic.b2w0", dataA[31:0], 32'h30);
      checkOutput("basic.last2", lastA, 1);
      tick();
      checkOutput("basic.done", doneA, 1);
      checkOutput("basic.validEnd", validA, 0);
      tick();

      // Pre-swapped instance
      cst = 32'h1; len = 1; startB = 1'b1;
      tick();
      startB = 1'b0;
      checkOutput("preswap.w0", dataB[31:0], 32'h0100_0000);
      checkOutput("preswap.w1", dataB[63:32], 32'h0200_0000);
      checkOutput("preswap.beat", dataB, modelBeat(32'h1, 0, 1'b1));
      checkOutput("preswap.last", lastB, 1);
      checkOutput("preswap.valid", validB, 1);
      tick();
      checkOutput("preswap.done", doneB, 1);
      tick();

      // Wrap of the 32-bit counter
      applyStimulus(32'hFFFF_FFF8, 2, 0, "wrap");
      applyStimulus($urandom, 4, 2, "backpressure");
      applyStimulus($urandom, 0, 0, "zero");
      for (int i = 0; i < 6; i++) begin
         applyStimulus($urandom, int'($urandom_range(1, 12)), 1, $sformatf("rand%0d", i));
      end

      // Reset in the middle of a burst
      saved = $urandom; cst = saved; len = 10; ready = 1'b1; startA = 1'b1;
      tick();
      startA = 1'b0;
      repeat (4) tick();
      checkOutput("rstMid.beat4", dataA, modelBeat(saved, 4, 1'b0));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("rstMid.valid", validA, 0);
      checkOutput("rstMid.done", doneA, 0);
      checkOutput("rstMid.busy", busyA, 0);
      checkOutput("rstMid.last", lastA, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("rstMid.idleDone%0d", i), doneA, 0);
         checkOutput($sformatf("rstMid.idleValid%0d", i), validA, 0);
      end
      cst = 32'h0; len = 1; startA = 1'b1;
      tick();
      startA = 1'b0;
      checkOutput("rstMid.newW0", dataA[31:0], 32'h0);
      checkOutput("rstMid.newBeat", dataA, modelBeat(32'h0, 0, 1'b0));
      checkOutput("rstMid.newLast", lastA, 1);
      tick();
      checkOutput("rstMid.newDone", doneA, 1);
      tick();

      // Reset and start together: the start is lost
      cst = $urandom; len = 5; reset = 1'b1; startA = 1'b1;
      tick();
      reset = 1'b0; startA = 1'b0;
      checkOutput("rstStart.valid", validA, 0);
      checkOutput("rstStart.busy", busyA, 0);
      tick();
      checkOutput("rstStart.validLater", validA, 0);
      checkOutput("rstStart.busyLater", busyA, 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/byteswap_stream_source.md
# byteswap_stream_source

AXI4-Stream source that transmits a counted burst of test words into the byte-swapper's slave stream port. It is the transmitting end of the swapper's input interface and is used for kernel bring-up and for hardware self-test without a memory reader. A control pulse launches a burst of `ctrl_length` beats; each 32-bit word is a running counter seeded from `ctrl_constant`. The counter can optionally be pre-byte-reversed so the swapper's output reads as a natural count.

## Interface

Parameters
- `C_AXIS_TDATA_WIDTH`, 512: stream data width in bits; must be a multiple of `C_WORD_BIT_WIDTH`.
- `C_WORD_BIT_WIDTH`, 32: counter word width in bits; must be a multiple of 8.
- `C_LENGTH_WIDTH`, 32: width of the beat-count input.
- `C_PRESWAP`, 0: 1 = reverse byte order within each word before transmitting.
- Derived: `LP_NUM_WORDS` = `C_AXIS_TDATA_WIDTH / C_WORD_BIT_WIDTH`.

Ports
- `m_axis_aclk`, in, 1: sole clock.
- `m_axis_areset`, in, 1: reset, synchronous, active-high.
- `ctrl_start`, in, 1: launch pulse; sampled only in IDLE.
- `ctrl_length`, in, `C_LENGTH_WIDTH`: beats in the burst; latched on start.
- `ctrl_constant`, in, `C_WORD_BIT_WIDTH`: first counter value; latched on start.
- `ctrl_busy`, out, 1: high while in RUN or DONE.
- `ctrl_done`, out, 1: one-cycle completion pulse.
- `m_axis_tvalid`, out, 1: output stream valid.
- `m_axis_tready`, in, 1: output stream ready.
- `m_axis_tdata`, out, `C_AXIS_TDATA_WIDTH`: output stream data.
- `m_axis_tkeep`, out, `C_AXIS_TDATA_WIDTH/8`: byte enables; all ones on every beat.
- `m_axis_tlast`, out, 1: marks the final beat of the burst.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE, on `ctrl_start`:
  - latch `ctrl_length` into the remaining-beat counter and `ctrl_constant` into the word base;
  - if the length is 0, go to DONE; otherwise go to RUN.
- RUN:
  - `m_axis_tvalid` is high.
  - Word k of the beat (bits `k*C_WORD_BIT_WIDTH +: C_WORD_BIT_WIDTH`) = base + k, mod 2^`C_WORD_BIT_WIDTH`.
  - If `C_PRESWAP`=1, each word's bytes are reversed: byte j takes byte (NUM_BYTES-1-j).
  - `m_axis_tlast` is high when the remaining count is 1.
- On each handshake (tvalid & tready):
  - base += `LP_NUM_WORDS`, wrapping mod 2^`C_WORD_BIT_WIDTH`;
  - remaining -= 1;
  - if the beat carried tlast, go to DONE.
- DONE: `ctrl_done` is high for exactly this one cycle, then the FSM returns to IDLE.
- `ctrl_start` is ignored in RUN and DONE.
- Burst length range: 0 to 2^`C_LENGTH_WIDTH`-1.
- AXIS rules:
  - while tvalid & !tready, tdata, tkeep and tlast hold stable;
  - tvalid never drops without a handshake, except on reset;
  - tvalid does not depend combinationally on tready.

## Timing

- Reset values: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `m_axis_tkeep`=all ones, `ctrl_busy`=0, `ctrl_done`=0; FSM in IDLE.
- Start latency: `ctrl_start` high at edge N makes tvalid high with beat 0 from edge N+1.
- Throughput: 1 beat per cycle while tready is high. L beats with tready tied high are transmitted in cycles N+1 .. N+L.
- Done timing:
  - `ctrl_done` is high in the cycle after the last handshake;
  - `ctrl_busy` falls one cycle after that;
  - for length 0, `ctrl_done` is high at N+1 and no beat is emitted.
- The next `ctrl_start` is accepted in the first cycle after DONE.
- Outputs are driven directly from registers; there is no combinational path from `ctrl_*` or `m_axis_tready` to any output.
- Reset mid-burst: takes effect at the next edge.
  - tvalid=0, FSM IDLE, no `ctrl_done`;
  - the partially sent burst is abandoned and no tlast is emitted.
- Reset and `ctrl_start` in the same cycle: reset wins and the start is lost.

## Test plan

- **Basic burst.** `C_PRESWAP`=0, constant=0x00000010, length=3, tready=1.
  - Beat0: word0=0x10, word15=0x1F. Beat1: word0=0x20. Beat2: word0=0x30, tlast=1.
  - `ctrl_done` is high the cycle after beat2; tkeep=0xFFFF_FFFF_FFFF_FFFF on all beats.
- **Pre-swap.** `C_PRESWAP`=1, constant=0x00000001, length=1.
  - word0=0x01000000, word1=0x02000000, tlast=1 on the only beat.
- **Wrap.** constant=0xFFFFFFF8, length=2.
  - Beat0: word7=0xFFFFFFFF, word8=0x00000000. Beat1: word0=0x00000008.
- **Backpressure.** length=4, tready pattern 1,0,0,1,0,1,1.
  - tdata and tlast are stable during stalls; exactly 4 handshakes with values in sequence; tlast only on the 4th.
  - A `ctrl_start` pulsed mid-burst has no effect.
- **Zero length.** length=0.
  - No tvalid, `ctrl_done` high at N+1, `ctrl_busy` high for 1 cycle.
- **Reset mid-burst.** length=10, assert reset after 4 handshakes.
  - tvalid=0 next cycle, no `ctrl_done`.
  - A new start with constant=0 then produces beat0 word0=0x00000000.
